// File: rtl/sparc_imem_pkg.sv
// Shared instruction-memory constants and loader state encoding,
// reused by the fetch stage, the loader and the bench.
package sparc_imem_pkg;

  localparam int unsigned IMEM_DEPTH  = 512;
  localparam int unsigned IMEM_ADDR_W = 9;

  // SPARC "sethi 0,%g0", fetched while a load is in progress
  localparam logic [31:0] NOP_WORD = 32'h0100_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
interface imem_stream_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_512x8_dp.sv
// Byte-wide instruction memory: one synchronous byte write port and one
// combinational big-endian 32-bit read port with modulo address wrap.
module imem_512x8_dp
  import sparc_imem_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [7:0] mem [DEPTH];

  logic [ADDR_W-1:0] a1, a2, a3;

  // Contents are deliberately not reset; a load overwrites what it needs.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    a1    = raddr + ADDR_W'(1);
    a2    = raddr + ADDR_W'(2);
    a3    = raddr + ADDR_W'(3);
    rdata = {mem[raddr], mem[a1], mem[a2], mem[a3]};
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Writer side of the instruction memory: loads a counted byte stream from
// address 0, zero-pads the final word and freezes the pipeline meanwhile.
module imem_stream_loader
  import sparc_imem_pkg::*;
#(
  parameter int unsigned DEPTH    = IMEM_DEPTH,
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter logic [31:0] NOP_WORD = sparc_imem_pkg::NOP_WORD
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      start,
  input  logic [ADDR_W:0]           len,
  imem_stream_loader_if.slave       stream,
  input  logic [ADDR_W-1:0]         fetch_addr,
  output logic [31:0]               fetch_data,
  output logic                      busy,
  output logic                      hold,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_W:0]           bytes_loaded
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, ptr_nxt;
  logic [LEN_W-1:0]  target, target_nxt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic              err_nxt;
  logic              we;
  logic [7:0]        wdata;
  logic [31:0]       rd_word;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      bytes_loaded <= '0;
      target       <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= ptr_nxt;
      bytes_loaded <= cnt_nxt;
      target       <= target_nxt;
      err          <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = wr_ptr;
    cnt_nxt    = bytes_loaded;
    target_nxt = target;
    err_nxt    = err;
    we         = 1'b0;
    wdata      = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (len > LEN_W'(DEPTH)) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else if (len == '0) begin
            err_nxt   = 1'b0;
            state_nxt = DONE;
          end else begin
            err_nxt    = 1'b0;
            ptr_nxt    = '0;
            cnt_nxt    = '0;
            target_nxt = len;
            state_nxt  = LOAD;
          end
        end
      end
      LOAD: begin
        // in_ready is constant 1 here, so in_valid alone marks a handshake
        if (stream.in_valid) begin
          we      = 1'b1;
          wdata   = stream.in_data;
          ptr_nxt = wr_ptr + ADDR_W'(1);
          cnt_nxt = bytes_loaded + LEN_W'(1);
          if (cnt_nxt == target)
            state_nxt = (target[1:0] == 2'b00) ? DONE : PAD;
        end
      end
      PAD: begin
        we      = 1'b1;
        wdata   = 8'h00;
        ptr_nxt = wr_ptr + ADDR_W'(1);
        if (wr_ptr[1:0] == 2'b11) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stream.in_ready = (state == LOAD);
  assign busy            = (state == LOAD) || (state == PAD);
  assign hold            = busy;
  assign done            = (state == DONE);
  assign fetch_data      = busy ? NOP_WORD : rd_word;

  imem_512x8_dp #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(fetch_addr),
    .rdata(rd_word)
  );

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: reset, loads, backpressure,
// padding, boundary lengths and reset mid-load.
module tb_imem_stream_loader;
  import sparc_imem_pkg::*;

  logic        clk;
  logic        clr;
  logic        start;
  logic [9:0]  len;
  logic [8:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        busy, hold, done, err;
  logic [9:0]  bytes_loaded;

  int n_cmp = 0;
  int n_mis = 0;

  imem_stream_loader_if s_if ();

  imem_stream_loader #(
    .DEPTH   (512),
    .ADDR_W  (9),
    .NOP_WORD(32'h0100_0000)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .len         (len),
    .stream      (s_if.slave),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .busy        (busy),
    .hold        (hold),
    .done        (done),
    .err         (err),
    .bytes_loaded(bytes_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    s_if.in_valid = 1'b1;
    s_if.in_data  = b;
    tick();
    s_if.in_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [8:0] a, input logic [31:0] exp);
    fetch_addr = a;
    #1;
    check(tag, fetch_data, exp);
  endtask

  logic [7:0] basic_bytes [8];
  logic [7:0] pad_bytes [6];
  logic       bp_pat [7];
  logic [7:0] bp_bytes [4];
  logic [9:0] bp_cnt [7];

  initial begin
    basic_bytes = '{8'h82, 8'h10, 8'h20, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00};
    pad_bytes   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    bp_pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bp_bytes    = '{8'h11, 8'h22, 8'h33, 8'h44};
    bp_cnt      = '{10'd1, 10'd1, 10'd1, 10'd2, 10'd3, 10'd3, 10'd4};

    clr = 1'b0; start = 1'b0; len = '0; fetch_addr = '0;
    s_if.in_valid = 1'b0; s_if.in_data = '0;

    // reset
    repeat (3) tick();
    check("rst_in_ready", 32'(s_if.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bytes", 32'(bytes_loaded), 32'd0);
    clr = 1'b1;
    repeat (2) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_in_ready", 32'(s_if.in_ready), 32'd0);

    // basic load, len 8
    do_start(10'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("basic_ready_%0d", i), 32'(s_if.in_ready), 32'd1);
      check($sformatf("basic_fetch_nop_%0d", i), fetch_data, 32'h0100_0000);
      send(basic_bytes[i]);
    end
    check("basic_ready_after", 32'(s_if.in_ready), 32'd0);
    check("basic_done", 32'(done), 32'd1);
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_bytes", 32'(bytes_loaded), 32'd8);
    fetch("basic_w0", 9'd0, 32'h8210_2005);
    fetch("basic_w1", 9'd4, 32'h0100_0000);

    // backpressure, len 4
    fetch_addr = 9'd0;
    do_start(10'd4);
    begin
      int k;
      k = 0;
      for (int i = 0; i < 7; i++) begin
        check($sformatf("bp_busy_%0d", i), 32'(busy), 32'd1);
        check($sformatf("bp_hold_%0d", i), 32'(hold), 32'd1);
        check($sformatf("bp_nop_%0d", i), fetch_data, NOP_WORD);
        s_if.in_valid = bp_pat[i];
        s_if.in_data  = bp_pat[i] ? bp_bytes[k] : 8'hEE;
        if (bp_pat[i]) k++;
        tick();
        s_if.in_valid = 1'b0;
        check($sformatf("bp_cnt_%0d", i), 32'(bytes_loaded), 32'(bp_cnt[i]));
      end
    end
    check("bp_done", 32'(done), 32'd1);
    fetch("bp_w0", 9'd0, 32'h1122_3344);

    // len > DEPTH rejected
    do_start(10'd513);
    check("big_err", 32'(err), 32'd1);
    check("big_done", 32'(done), 32'd0);
    check("big_busy", 32'(busy), 32'd0);
    tick();
    check("big_in_ready", 32'(s_if.in_ready), 32'd0);
    fetch("big_mem", 9'd0, 32'h1122_3344);

    // len 0
    do_start(10'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(err), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    fetch("zero_mem", 9'd0, 32'h1122_3344);

    // start pulsed during LOAD
    do_start(10'd4);
    send(8'hA1);
    send(8'hA2);
    start = 1'b1; len = 10'd0;
    send(8'hA3);
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_cnt", 32'(bytes_loaded), 32'd3);
    send(8'hA4);
    check("ign_done", 32'(done), 32'd1);
    check("ign_cnt_end", 32'(bytes_loaded), 32'd4);
    fetch("ign_w0", 9'd0, 32'hA1A2_A3A4);

    // full 512-byte load, byte i = (7*i + 3) mod 256
    do_start(10'd512);
    for (int i = 0; i < 512; i++) send(8'(i * 7 + 3));
    check("full_done", 32'(done), 32'd1);
    check("full_bytes", 32'(bytes_loaded), 32'd512);
    fetch("full_wrap", 9'd510, 32'hF5FC_030A);
    fetch("full_w4", 9'd4, 32'h1F26_2D34);

    // padding, len 6
    fetch_addr = 9'd0;
    do_start(10'd6);
    for (int i = 0; i < 6; i++) send(pad_bytes[i]);
    check("pad_busy0", 32'(busy), 32'd1);
    check("pad_ready0", 32'(s_if.in_ready), 32'd0);
    check("pad_done0", 32'(done), 32'd0);
    tick();
    check("pad_busy1", 32'(busy), 32'd1);
    check("pad_nop1", fetch_data, NOP_WORD);
    tick();
    check("pad_done", 32'(done), 32'd1);
    check("pad_bytes", 32'(bytes_loaded), 32'd6);
    fetch("pad_w0", 9'd0, 32'hAABB_CCDD);
    fetch("pad_w1", 9'd4, 32'hEEFF_0000);

    // reset mid-load
    fetch_addr = 9'd0;
    do_start(10'd8);
    send(8'h5A);
    send(8'h6B);
    send(8'h7C);
    clr = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_hold", 32'(hold), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_ready", 32'(s_if.in_ready), 32'd0);
    fetch("mid_keep", 9'd0, 32'h5A6B_7CDD);
    tick();
    clr = 1'b1;
    tick();
    do_start(10'd4);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    check("fresh_done", 32'(done), 32'd1);
    check("fresh_bytes", 32'(bytes_loaded), 32'd4);
    fetch("fresh_w0", 9'd0, 32'h0102_0304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
